pwm_duty_seq: RTL and testbench

// - Duty-cycle sequencer for the 0..100-step PWM output stage; generates the 7-bit duty word.
// - Accepts SET / RAMP / BREATHE / STOP commands from lock control logic (status LED, buzzer fade).
// - Changes duty only at PWM period boundaries, so a period never sees a mid-period duty change.

---
 rtl/pwm_duty_seq.sv | 130 +++++++++++++
 tb/tb_pwm_duty_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_seq.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_seq
// Purpose : Duty-word sequencer (SET / RAMP / BREATHE / STOP) for a PWM stage;
//           duty changes only on PWM period boundaries.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_duty_seq #(
  parameter int PERIOD   = 100,
  parameter int DUTY_MAX = 100,
  parameter int RATE_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [6:0]        cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  output logic [6:0]        duty,
  output logic              busy,
  output logic              done,
  output logic              period_end
);

  localparam int                PCNT_W    = $clog2(PERIOD);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
  localparam logic [6:0]        DUTY_CAP  = 7'(DUTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_RAMP  = 3'd2,
    S_BR_UP = 3'd3,
    S_BR_DN = 3'd4
  } state_t;

  state_t            state;
  logic [PCNT_W-1:0] pcnt;
  logic [6:0]        tgt;
  logic [RATE_W-1:0] rate;
  logic [RATE_W-1:0] rate_cnt;

  logic              accept;
  logic              step_due;
  logic [6:0]        tgt_clamped;
  logic [RATE_W-1:0] rate_eff;

  assign period_end  = (pcnt == PCNT_LAST);
  assign cmd_ready   = rst_n & ((state == S_IDLE) | (state == S_BR_UP) | (state == S_BR_DN));
  assign accept      = cmd_valid & cmd_ready;
  assign busy        = (state != S_IDLE);
  assign step_due    = (rate_cnt == rate - RATE_W'(1));
  assign tgt_clamped = (cmd_target > DUTY_CAP) ? DUTY_CAP : cmd_target;
  assign rate_eff    = (cmd_rate == '0) ? RATE_W'(1) : cmd_rate;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt     <= '0;
      duty     <= '0;
      state    <= S_IDLE;
      done     <= 1'b0;
      rate_cnt <= '0;
      rate     <= RATE_W'(1);
      tgt      <= '0;
    end else begin
      done <= 1'b0;
      pcnt <= period_end ? '0 : pcnt + PCNT_W'(1);

      // A new command wins over boundary work, so it always starts from the current duty.
      if (accept) begin
        rate_cnt <= '0;
        rate     <= rate_eff;
        case (cmd_mode)
          2'b00: begin
            tgt   <= tgt_clamped;
            state <= S_PEND;
          end
          2'b01: begin
            tgt   <= tgt_clamped;
            state <= S_RAMP;
          end
          2'b10: begin
            tgt   <= tgt_clamped;
            state <= S_BR_UP;
          end
          default: begin
            tgt   <= '0;
            state <= S_PEND;
          end
        endcase
      end else if (period_end) begin
        if (state == S_RAMP || state == S_BR_UP || state == S_BR_DN)
          rate_cnt <= step_due ? '0 : rate_cnt + RATE_W'(1);

        unique case (state)
          S_PEND: begin
            duty  <= tgt;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          S_RAMP: begin
            if (duty == tgt) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (step_due) begin
              duty <= (duty < tgt) ? duty + 7'd1 : duty - 7'd1;
            end
          end
          S_BR_UP: begin
            // Turnaround boundaries replace the step; >= also covers starting above target.
            if (duty >= tgt)
              state <= S_BR_DN;
            else if (step_due && duty < DUTY_CAP)
              duty <= duty + 7'd1;
          end
          S_BR_DN: begin
            if (duty == 7'd0)
              state <= S_BR_UP;
            else if (step_due)
              duty <= duty - 7'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_duty_seq
// Purpose : Directed + randomized bench for pwm_duty_seq against a
//           behavioural duty model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_duty_seq;

  localparam int PERIOD   = 100;
  localparam int DUTY_MAX = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [6:0] cmd_target;
  logic [7:0] cmd_rate;
  logic [6:0] duty;
  logic       busy;
  logic       done;
  logic       period_end;

  always #5 clk = ~clk;

  pwm_duty_seq #(.PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .RATE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .duty       (duty),
    .busy       (busy),
    .done       (done),
    .period_end (period_end)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {A_IDLE, A_PENDING, A_RAMPING, A_BREATHING} act_t;
  act_t act = A_IDLE;
  int   m_pcnt, m_duty, m_goal, m_rate, m_elapsed;
  bit   m_rising, m_done, m_acc, m_bnd, m_step;
  bit   chk_en = 1'b0;

  function automatic bit exp_ready();
    return (rst_n === 1'b1) && (act == A_IDLE || act == A_BREATHING);
  endfunction

  always @(posedge clk) begin
    m_acc  = 1'b0;
    m_bnd  = 1'b0;
    m_done = 1'b0;
    if (rst_n !== 1'b1) begin
      m_pcnt = 0; m_duty = 0; act = A_IDLE; m_elapsed = 0;
    end else begin
      m_bnd = (m_pcnt == PERIOD - 1);
      if (cmd_valid === 1'b1 && exp_ready()) begin
        m_acc     = 1'b1;
        m_goal    = (int'(cmd_target) > DUTY_MAX) ? DUTY_MAX : int'(cmd_target);
        m_rate    = (cmd_rate == 0) ? 1 : int'(cmd_rate);
        m_elapsed = 0;
        case (cmd_mode)
          2'd0:    act = A_PENDING;
          2'd1:    act = A_RAMPING;
          2'd2:    begin act = A_BREATHING; m_rising = 1'b1; end
          default: begin act = A_PENDING; m_goal = 0; end
        endcase
      end else if (m_bnd) begin
        // one step allowed every m_rate periods
        m_elapsed++;
        m_step = (m_elapsed == m_rate);
        if (m_step) m_elapsed = 0;
        case (act)
          A_PENDING: begin m_duty = m_goal; m_done = 1'b1; act = A_IDLE; end
          A_RAMPING: begin
            if (m_duty == m_goal) begin m_done = 1'b1; act = A_IDLE; end
            else if (m_step) m_duty += (m_goal > m_duty) ? 1 : -1;
          end
          A_BREATHING: begin
            if (m_rising) begin
              if (m_duty >= m_goal) m_rising = 1'b0;
              else if (m_step) m_duty++;
            end else begin
              if (m_duty == 0) m_rising = 1'b1;
              else if (m_step) m_duty--;
            end
          end
          default: ;
        endcase
      end
      m_pcnt = m_bnd ? 0 : m_pcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("duty", duty, m_duty);
      check("done", done, m_done);
      check("busy", busy, act != A_IDLE);
      check("cmd_ready", cmd_ready, exp_ready());
      check("period_end", period_end, m_pcnt == PERIOD - 1);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int mode, input int tgt, input int rate);
    int n = 0;
    cmd_mode   = 2'(mode);
    cmd_target = 7'(tgt);
    cmd_rate   = 8'(rate);
    cmd_valid  = 1'b1;
    do begin tick(); n++; end while (!m_acc && n < 6000);
    check("accept_timeout", m_acc, 1);
    cmd_valid  = 1'b0;
    cmd_mode   = 2'($urandom);
    cmd_target = 7'($urandom);
    cmd_rate   = 8'($urandom);
  endtask

  task automatic next_bnd();
    int n = 0;
    do begin tick(); n++; end while (!m_bnd && n < PERIOD + 2);
  endtask

  task automatic wait_pcnt(input int p);
    int n = 0;
    do begin tick(); n++; end while (m_pcnt != p && n < PERIOD + 2);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (act != A_IDLE && n < limit) begin tick(); n++; end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int br_exp [9] = '{1, 2, 3, 3, 2, 1, 0, 0, 1};
    int op, mode, rate, tgt;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_target = '0; cmd_rate = '0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", cmd_ready, 1);

    // SET 60 accepted at pcnt=10: boundary is 89 edges after acceptance
    wait_pcnt(10);
    issue(0, 60, 0);
    repeat (88) tick();
    check("set60_before", duty, 0);
    tick();
    check("set60_duty", duty, 60);
    check("set60_done", done, 1);
    tick();
    check("set60_done_1clk", done, 0);

    issue(0, 120, 5);
    next_bnd();
    check("set120_clamp", duty, 100);
    check("set120_done", done, 1);

    // accept on the period_end edge: update lands a full period later
    wait_pcnt(99);
    issue(0, 30, 0);
    repeat (99) tick();
    check("set_at_bnd_hold", duty, 100);
    tick();
    check("set_at_bnd_duty", duty, 30);
    check("set_at_bnd_done", done, 1);

    // RAMP with rate 0 from 5 down to 2
    issue(0, 5, 0);
    next_bnd();
    issue(1, 2, 0);
    next_bnd(); check("ramp_dn_4", duty, 4);
    next_bnd(); check("ramp_dn_3", duty, 3);
    next_bnd(); check("ramp_dn_2", duty, 2);
    check("ramp_dn_busy", busy, 1);
    next_bnd();
    check("ramp_dn_done", done, 1);
    check("ramp_dn_final", duty, 2);

    // RAMP to 5 at rate 2 from 0
    issue(0, 0, 0);
    next_bnd();
    issue(1, 5, 2);
    wait_idle(2000);
    check("ramp_up_final", duty, 5);

    // BREATHE 3 at rate 1 from 0
    issue(0, 0, 0);
    next_bnd();
    issue(2, 3, 1);
    for (int i = 0; i < 9; i++) begin
      next_bnd();
      check("breathe_seq", duty, br_exp[i]);
      check("breathe_busy", busy, 1);
    end
    next_bnd();
    check("breathe_at2", duty, 2);
    check("stop_ready", cmd_ready, 1);
    issue(3, 77, 9);
    next_bnd();
    check("stop_duty", duty, 0);
    check("stop_done", done, 1);
    check("stop_idle", busy, 0);

    // reset in the middle of a RAMP
    issue(1, 50, 0);
    repeat (3) next_bnd();
    check("ramp_mid", duty, 3);
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_duty", duty, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        tick();
        rst_n = 1'b0;
        repeat (int'($urandom_range(1, 2))) tick();
        rst_n = 1'b1;
      end else begin
        mode = int'($urandom_range(0, 3));
        rate = int'($urandom_range(0, 2));
        if (mode == 1) begin
          tgt = int'($urandom_range(0, 8));
          tgt = m_duty + tgt - 4;
          if (tgt < 0) tgt = 0;
          if (tgt > 127) tgt = 127;
        end else if (mode == 2) begin
          tgt = int'($urandom_range(0, 8));
        end else begin
          tgt = int'($urandom_range(0, 127));
        end
        issue(mode, tgt, rate);
        if (mode == 2)
          repeat (int'($urandom_range(1, 12))) next_bnd();
        else if ($urandom_range(0, 1) == 1)
          wait_idle(3000);
        else
          repeat (int'($urandom_range(0, 150))) tick();
      end
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
